// File: rtl/cnn_pkg.sv
// Shared CNN accelerator constants and types, also used by the ram_cnn buffer users.
package cnn_pkg;

  localparam int CNN_CH      = 16;
  localparam int CNN_IN_DIM  = 26;
  localparam int CNN_OUT_DIM = 13;
  localparam int CNN_A_AW    = 14;
  localparam int CNN_B_AW    = 12;

  typedef enum logic [2:0] {
    MP_IDLE,
    MP_RD,
    MP_LAST,
    MP_WR,
    MP_DONE
  } mp_state_t;

endpackage

// File: rtl/pool_addr_gen.sv
// Pixel counters and incremental buffer A/B address generation for maxpool_ctrl.
// Window base steps by 2 along a row and by IN_DIM+2 at row/channel wrap (adds only).
module pool_addr_gen
  import cnn_pkg::*;
#(
  parameter int CH      = CNN_CH,
  parameter int IN_DIM  = CNN_IN_DIM,
  parameter int OUT_DIM = CNN_OUT_DIM
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                rd,
  input  logic [1:0]          k,
  input  logic                latch_b,
  input  logic                adv,
  output logic [CNN_A_AW-1:0] a_addr,
  output logic [CNN_B_AW-1:0] b_addr,
  output logic                last_pix
);

  localparam int PW = $clog2(OUT_DIM + 1);
  localparam int CW = $clog2(CH + 1);

  logic [PW-1:0]       px, py;
  logic [CW-1:0]       c;
  logic [CNN_A_AW-1:0] base, base_nxt, tap_off;
  logic [CNN_B_AW-1:0] b_idx;
  logic                px_last, py_last;

  assign px_last  = (px == PW'(OUT_DIM - 1));
  assign py_last  = (py == PW'(OUT_DIM - 1));
  assign last_pix = px_last && py_last && (c == CW'(CH - 1));
  // IN_DIM is even, so skipping a row pair and crossing into the next channel both add IN_DIM+2
  assign base_nxt = base + (px_last ? CNN_A_AW'(IN_DIM + 2) : CNN_A_AW'(2));

  always_comb begin
    tap_off = CNN_A_AW'(IN_DIM + 1);
    case (k)
      2'd0:    tap_off = CNN_A_AW'(1);
      2'd1:    tap_off = CNN_A_AW'(IN_DIM);
      default: tap_off = CNN_A_AW'(IN_DIM + 1);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px     <= '0;
      py     <= '0;
      c      <= '0;
      base   <= '0;
      b_idx  <= '0;
      a_addr <= '0;
      b_addr <= '0;
    end else begin
      if (clr) begin
        px     <= '0;
        py     <= '0;
        c      <= '0;
        base   <= '0;
        b_idx  <= '0;
        a_addr <= '0;
      end else if (rd && k != 2'd3) begin
        a_addr <= base + tap_off;
      end else if (adv && !last_pix) begin
        base   <= base_nxt;
        a_addr <= base_nxt;
        b_idx  <= b_idx + CNN_B_AW'(1);
        if (px_last) begin
          px <= '0;
          if (py_last) begin
            py <= '0;
            c  <= c + CW'(1);
          end else begin
            py <= py + PW'(1);
          end
        end else begin
          px <= px + PW'(1);
        end
      end
      if (latch_b) b_addr <= b_idx;
    end
  end

endmodule

// File: rtl/maxpool_ctrl.sv
// 2x2 stride-2 signed max-pool over buffer A into buffer B, 6 cycles per output pixel.
// MAXPOOL_RELU_EN: clamp negative pooled values to 0 on the buffer B write.
module maxpool_ctrl
  import cnn_pkg::*;
#(
  parameter int CH      = CNN_CH,
  parameter int IN_DIM  = CNN_IN_DIM,
  parameter int OUT_DIM = CNN_OUT_DIM
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [CNN_A_AW-1:0] buf_a_addr,
  input  logic [7:0]          buf_a_rd_data,
  output logic [CNN_B_AW-1:0] buf_b_addr,
  output logic [7:0]          buf_b_wr_data,
  output logic                buf_b_wr_en
);

  mp_state_t  state, state_nxt;
  logic [1:0] k, k_nxt;
  logic [7:0] max_q;
  logic       clr, rd, latch_b, adv, last_pix;

  pool_addr_gen #(
    .CH      (CH),
    .IN_DIM  (IN_DIM),
    .OUT_DIM (OUT_DIM)
  ) u_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .rd       (rd),
    .k        (k),
    .latch_b  (latch_b),
    .adv      (adv),
    .a_addr   (buf_a_addr),
    .b_addr   (buf_b_addr),
    .last_pix (last_pix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MP_IDLE;
      k     <= 2'd0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    clr       = 1'b0;
    rd        = 1'b0;
    latch_b   = 1'b0;
    adv       = 1'b0;
    case (state)
      MP_IDLE: begin
        if (start) begin
          state_nxt = MP_RD;
          k_nxt     = 2'd0;
          clr       = 1'b1;
        end
      end
      MP_RD: begin
        rd    = 1'b1;
        k_nxt = k + 2'd1;
        if (k == 2'd3) state_nxt = MP_LAST;
      end
      MP_LAST: begin
        latch_b   = 1'b1;
        state_nxt = MP_WR;
      end
      MP_WR: begin
        adv       = 1'b1;
        k_nxt     = 2'd0;
        state_nxt = last_pix ? MP_DONE : MP_RD;
      end
      MP_DONE: state_nxt = MP_IDLE;
      default: state_nxt = MP_IDLE;
    endcase
  end

  assign busy        = (state == MP_RD) || (state == MP_LAST) || (state == MP_WR);
  assign done        = (state == MP_DONE);
  assign buf_b_wr_en = (state == MP_WR);

  // Read data lags the address by one cycle, so RD k=1 sees tap 0 and LAST sees tap 3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= 8'd0;
    end else if (state == MP_RD && k == 2'd1) begin
      max_q <= buf_a_rd_data;
    end else if (((state == MP_RD && k >= 2'd2) || state == MP_LAST) &&
                 ($signed(buf_a_rd_data) > $signed(max_q))) begin
      max_q <= buf_a_rd_data;
    end
  end

`ifdef MAXPOOL_RELU_EN
  assign buf_b_wr_data = max_q[7] ? 8'd0 : max_q;
`else
  assign buf_b_wr_data = max_q;
`endif

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Self-checking bench for maxpool_ctrl: ramp and random maps against a window-max model.
module tb_maxpool_ctrl;

  localparam int CH  = 16;
  localparam int IN  = 26;
  localparam int OUT = 13;
  localparam int NA  = CH * IN * IN;
  localparam int NB  = CH * OUT * OUT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done;
  logic [13:0] buf_a_addr;
  logic [7:0]  buf_a_rd_data;
  logic [11:0] buf_b_addr;
  logic [7:0]  buf_b_wr_data;
  logic        buf_b_wr_en;

  logic [7:0] amem [NA];
  logic [7:0] bmem [NB];

  int checks   = 0;
  int failures = 0;
  int exp_idx  = 0;
  int wr_cnt   = 0;

  maxpool_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .buf_a_addr    (buf_a_addr),
    .buf_a_rd_data (buf_a_rd_data),
    .buf_b_addr    (buf_b_addr),
    .buf_b_wr_data (buf_b_wr_data),
    .buf_b_wr_en   (buf_b_wr_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pooled value straight from the window definition
  function automatic int exp_pix(input int idx);
    int c, r, py, px, base, m, v;
    c    = idx / (OUT * OUT);
    r    = idx % (OUT * OUT);
    py   = r / OUT;
    px   = r % OUT;
    base = c * IN * IN + 2 * py * IN + 2 * px;
    m    = -1000;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        v = int'($signed(amem[base + dy * IN + dx]));
        if (v > m) m = v;
      end
`ifdef MAXPOOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return m & 255;
  endfunction

  always @(posedge clk) buf_a_rd_data <= amem[int'(buf_a_addr)];

  always @(negedge clk) begin
    if (buf_b_wr_en) begin
      if (exp_idx < NB) begin
        chk("b_addr", 32'(buf_b_addr), 32'(exp_idx));
        chk("b_data", 32'(buf_b_wr_data), 32'(exp_pix(exp_idx)));
      end
      if (int'(buf_b_addr) < NB) bmem[int'(buf_b_addr)] = buf_b_wr_data;
      exp_idx++;
      wr_cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input bit extra_starts);
    int cyc, busy_cnt, done_cnt, first_wr, done_cyc;
    busy_cnt = 0; done_cnt = 0; first_wr = 0; done_cyc = 0;
    for (int i = 0; i < NB; i++) bmem[i] = 8'h00;
    exp_idx = 0;
    wr_cnt  = 0;
    start   = 1'b1;
    tick;
    start = 1'b0;
    cyc   = 1;
    while (cyc <= 20000) begin
      if (busy) busy_cnt++;
      if (buf_b_wr_en && first_wr == 0) first_wr = cyc;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_cyc != 0 && cyc == done_cyc + 1) chk("start_in_done_ignored", 32'(busy), 32'd0);
      if (done_cyc != 0 && cyc == done_cyc + 4) break;
      if (extra_starts && (cyc == 5 || cyc == 100)) start = 1'b1;
      if (done_cyc != 0 && cyc == done_cyc) start = 1'b1;
      tick;
      start = 1'b0;
      cyc++;
    end
    chk("done_cycle", 32'(done_cyc), 32'd16225);
    chk("busy_cycles", 32'(busy_cnt), 32'd16224);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("wr_strobes", 32'(wr_cnt), 32'd2704);
    chk("first_wr_cycle", 32'(first_wr), 32'd6);
  endtask

  initial begin
    int w0, first;
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < NA; i++) amem[i] = 8'(i % 128);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_en", 32'(buf_b_wr_en), 32'd0);
    chk("rst_a_addr", 32'(buf_a_addr), 32'd0);
    chk("rst_b_addr", 32'(buf_b_addr), 32'd0);
    chk("rst_wr_data", 32'(buf_b_wr_data), 32'd0);
    rst_n = 1'b1;
    tick;

    // Ramp map with stray starts mid-pass
    run_pass(1'b1);
    chk("ramp_b0", 32'(bmem[0]), 32'd27);
    chk("ramp_b1", 32'(bmem[1]), 32'd29);
    chk("ramp_b169", 32'(bmem[169]), 32'd63);
    chk("ramp_a_addr_hold", 32'(buf_a_addr), 32'd10815);
    chk("ramp_b_addr_hold", 32'(buf_b_addr), 32'd2703);

    // Random map with hand-built windows at pixels 0..2
    for (int i = 0; i < NA; i++) amem[i] = 8'($urandom_range(0, 255));
    amem[0]  = 8'hFB; amem[1]  = 8'hFD; amem[26] = 8'h9C; amem[27] = 8'h80;
    amem[2]  = 8'h7F; amem[3]  = 8'h7F; amem[28] = 8'h7F; amem[29] = 8'h7F;
    amem[4]  = 8'h01; amem[5]  = 8'h01; amem[30] = 8'h01; amem[31] = 8'h10;
    run_pass(1'b0);
`ifdef MAXPOOL_RELU_EN
    chk("neg_window", 32'(bmem[0]), 32'h00);
`else
    chk("neg_window", 32'(bmem[0]), 32'hFD);
`endif
    chk("equal_window", 32'(bmem[1]), 32'h7F);
    chk("tap3_max", 32'(bmem[2]), 32'h10);

    // Abort mid-pass at cycle 500, then restart from pixel 0
    exp_idx = 0;
    start   = 1'b1;
    tick;
    start = 1'b0;
    repeat (499) tick;
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wr_en", 32'(buf_b_wr_en), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_a_addr", 32'(buf_a_addr), 32'd0);
    chk("abort_b_addr", 32'(buf_b_addr), 32'd0);
    chk("abort_wr_data", 32'(buf_b_wr_data), 32'd0);
    w0 = wr_cnt;
    repeat (3) tick;
    rst_n = 1'b1;
    repeat (20) tick;
    chk("no_wr_after_abort", 32'(wr_cnt), 32'(w0));
    chk("idle_after_abort", 32'(busy), 32'd0);
    exp_idx = 0;
    start   = 1'b1;
    tick;
    start = 1'b0;
    first = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (buf_b_wr_en && first == 0) first = cyc;
      tick;
    end
    chk("restart_first_wr", 32'(first), 32'd6);
    repeat (60) tick;
    chk("restart_progress", 32'(exp_idx), 32'd13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
